ps2_key_event_ctrl: RTL and testbench

- Sequences raw PS/2 scan bytes from the keyboard receiver (1-cycle byte strobe plus 8-bit byte) into decoded key events.
- Tracks the E0 (extended) and F0 (break) prefixes, the currently held key, typematic repeats and the key-press count.
- Queues make/break events in a small FIFO with a valid/ready handshake.
- Sits between ps2_keyboard and the LUT/seven-segment display path; supplies held code, press count and display blank.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/key_evt_fifo.sv | 58 +++++
 rtl/ps2_key_event_ctrl.sv | 130 +++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event record for the PS/2 key event path.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_evt_t;

   // Keyboard control/response codes that carry no key information in IDLE.
   function automatic logic is_ignored(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead synchronous FIFO of key events with full/empty flags.
module key_evt_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     resetn,
   input  logic     wr_en,
   input  key_evt_t wr_data,
   input  logic     rd_en,
   output key_evt_t rd_data,
   output logic     full,
   output logic     empty,
   output logic     wr_drop
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   key_evt_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign pop     = rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
   assign push    = wr_en & (~full | pop);
   assign wr_drop = wr_en & full & ~pop;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Decodes PS/2 scan bytes into make/break events, tracks the held key and press count.
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          REPEAT_EN  = 1'b0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       evt_ready,
   input  logic       ovf_clr,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       key_held,
   output logic [7:0] held_code,
   output logic       held_ext,
   output logic [7:0] press_count,
   output logic       disp_blank,
   output logic       overflow
);

   ps2_state_t state, state_nxt;
   logic       is_make;
   logic       is_brk;
   logic       code_ext;
   logic       is_repeat;
   logic       push;
   logic       fifo_empty;
   logic       fifo_full;
   logic       wr_drop;
   key_evt_t   new_evt;
   key_evt_t   head_evt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (byte_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (byte_data == PS2_EXT)      state_nxt = ST_EXT;
               else if (byte_data == PS2_BRK) state_nxt = ST_BRK;
               else                           state_nxt = ST_IDLE;
            end
            ST_EXT: begin
               if (byte_data == PS2_BRK)      state_nxt = ST_EXT_BRK;
               else if (byte_data == PS2_EXT) state_nxt = ST_EXT;
               else                           state_nxt = ST_IDLE;
            end
            ST_BRK: begin
               if (byte_data == PS2_EXT)      state_nxt = ST_EXT_BRK;
               else if (byte_data == PS2_BRK) state_nxt = ST_BRK;
               else                           state_nxt = ST_IDLE;
            end
            ST_EXT_BRK: begin
               if (byte_data == PS2_EXT || byte_data == PS2_BRK) state_nxt = ST_EXT_BRK;
               else                                              state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      is_make  = 1'b0;
      is_brk   = 1'b0;
      code_ext = 1'b0;
      if (byte_valid && byte_data != PS2_EXT && byte_data != PS2_BRK) begin
         unique case (state)
            ST_IDLE:    is_make = ~is_ignored(byte_data);
            ST_EXT:     begin is_make = 1'b1; code_ext = 1'b1; end
            ST_BRK:     is_brk = 1'b1;
            ST_EXT_BRK: begin is_brk = 1'b1; code_ext = 1'b1; end
            default:    is_make = 1'b0;
         endcase
      end
   end

   assign is_repeat = key_held && (byte_data == held_code) && (code_ext == held_ext);
   assign push      = is_brk | (is_make & (~is_repeat | REPEAT_EN));
   assign new_evt   = '{code: byte_data, ext: code_ext, brk: is_brk};

   // Break only clears the held state when it names the held key; held code/ext persist.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_held    <= 1'b0;
         held_code   <= '0;
         held_ext    <= 1'b0;
         press_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (is_make && !is_repeat) begin
            key_held    <= 1'b1;
            held_code   <= byte_data;
            held_ext    <= code_ext;
            press_count <= press_count + 8'd1;
         end else if (is_brk && is_repeat) begin
            key_held <= 1'b0;
         end
         if (wr_drop)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (push),
      .wr_data (new_evt),
      .rd_en   (evt_ready),
      .rd_data (head_evt),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .wr_drop (wr_drop)
   );

   assign evt_valid  = ~fifo_empty;
   assign evt_code   = head_evt.code;
   assign evt_ext    = head_evt.ext;
   assign evt_break  = head_evt.brk;
   assign disp_blank = ~key_held;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: one DUT with repeats suppressed, one with repeats queued.
module tb_ps2_key_event_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = '0;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;

   logic       evt_valid0, evt_ext0, evt_break0, key_held0, held_ext0, disp_blank0, overflow0;
   logic [7:0] evt_code0, held_code0, press_count0;
   logic       evt_valid1, evt_ext1, evt_break1, key_held1, held_ext1, disp_blank1, overflow1;
   logic [7:0] evt_code1, held_code1, press_count1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ps2_key_event_ctrl #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0)) dut0 (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid0), .evt_code(evt_code0),
      .evt_ext(evt_ext0), .evt_break(evt_break0), .key_held(key_held0), .held_code(held_code0),
      .held_ext(held_ext0), .press_count(press_count0), .disp_blank(disp_blank0), .overflow(overflow0)
   );

   ps2_key_event_ctrl #(.FIFO_DEPTH(4), .REPEAT_EN(1'b1)) dut1 (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid1), .evt_code(evt_code1),
      .evt_ext(evt_ext1), .evt_break(evt_break1), .key_held(key_held1), .held_code(held_code1),
      .held_ext(held_ext1), .press_count(press_count1), .disp_blank(disp_blank1), .overflow(overflow1)
   );

   typedef struct {
      logic       bv;
      logic [7:0] bd;
      logic       rdy;
      logic       valid;
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       held;
      logic [7:0] hcode;
      logic       hext;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[26];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
      end
   endtask

   task automatic step(input logic bv, input logic [7:0] bd, input logic rdy, input logic clr);
      byte_valid = bv;
      byte_data  = bd;
      evt_ready  = rdy;
      ovf_clr    = clr;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_data  = '0;
      evt_ready  = 1'b0;
      ovf_clr    = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   logic [7:0] seq_codes[5];
   logic [7:0] c;
   int n0, n1;

   initial begin
      // bv bd rdy | valid code ext brk | held hcode hext cnt
      tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1};
      tbl[2]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1};
      tbl[3]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 8'd1};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd1};
      tbl[5]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd1};
      tbl[6]  = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2};
      tbl[8]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2};
      tbl[9]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2};
      tbl[10] = '{1'b1, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[13] = '{1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[14] = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[15] = '{1'b1, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'd2};
      tbl[17] = '{1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[18] = '{1'b1, 8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[19] = '{1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[20] = '{1'b1, 8'h24, 1'b0, 1'b1, 8'h24, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[22] = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[23] = '{1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
      tbl[24] = '{1'b1, 8'h74, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0, 1'b1, 8'h74, 1'b1, 8'd4};
      tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h74, 1'b1, 8'd4};

      do_reset();
      chk("rst.evt_valid", 8'(evt_valid0), 8'h00);
      chk("rst.evt_code", evt_code0, 8'h00);
      chk("rst.key_held", 8'(key_held0), 8'h00);
      chk("rst.held_code", held_code0, 8'h00);
      chk("rst.press_count", press_count0, 8'h00);
      chk("rst.overflow", 8'(overflow0), 8'h00);
      chk("rst.disp_blank", 8'(disp_blank0), 8'h01);

      for (int i = 0; i < 26; i++) begin
         step(tbl[i].bv, tbl[i].bd, tbl[i].rdy, 1'b0);
         chk($sformatf("row%0d.valid", i), 8'(evt_valid0), 8'(tbl[i].valid));
         chk($sformatf("row%0d.code", i), evt_code0, tbl[i].code);
         chk($sformatf("row%0d.ext", i), 8'(evt_ext0), 8'(tbl[i].ext));
         chk($sformatf("row%0d.brk", i), 8'(evt_break0), 8'(tbl[i].brk));
         chk($sformatf("row%0d.held", i), 8'(key_held0), 8'(tbl[i].held));
         chk($sformatf("row%0d.hcode", i), held_code0, tbl[i].hcode);
         chk($sformatf("row%0d.hext", i), 8'(held_ext0), 8'(tbl[i].hext));
         chk($sformatf("row%0d.cnt", i), press_count0, tbl[i].cnt);
         chk($sformatf("row%0d.blank", i), 8'(disp_blank0), 8'(!tbl[i].held));
         chk($sformatf("row%0d.ovf", i), 8'(overflow0), 8'h00);
      end

      // Repeats: suppressed in dut0, queued in dut1.
      do_reset();
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      chk("rep.cnt0", press_count0, 8'd1);
      chk("rep.cnt1", press_count1, 8'd1);
      chk("rep.ovf1", 8'(overflow1), 8'h00);
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 5; k++) begin
         if (evt_valid0) n0++;
         if (evt_valid1) begin
            n1++;
            chk($sformatf("rep.code1_%0d", k), evt_code1, 8'h1C);
            chk($sformatf("rep.brk1_%0d", k), 8'(evt_break1), (k == 3) ? 8'h01 : 8'h00);
         end
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("rep.events0", 8'(n0), 8'd2);
      chk("rep.events1", 8'(n1), 8'd4);

      // Full FIFO with a pop and a push in the same cycle.
      do_reset();
      seq_codes[0] = 8'h15; seq_codes[1] = 8'h1D; seq_codes[2] = 8'h24;
      seq_codes[3] = 8'h2D; seq_codes[4] = 8'h3C;
      for (int k = 0; k < 4; k++) step(1'b1, seq_codes[k], 1'b0, 1'b0);
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("simul.ovf", 8'(overflow0), 8'h00);
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("simul.valid%0d", k), 8'(evt_valid0), 8'h01);
         chk($sformatf("simul.code%0d", k), evt_code0, seq_codes[k]);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("simul.empty", 8'(evt_valid0), 8'h00);

      // Overflow on six makes, clear, then drain in order.
      do_reset();
      seq_codes[4] = 8'h2C;
      for (int k = 0; k < 5; k++) step(1'b1, seq_codes[k], 1'b0, 1'b0);
      step(1'b1, 8'h35, 1'b0, 1'b0);
      chk("ovf.set", 8'(overflow0), 8'h01);
      chk("ovf.cnt", press_count0, 8'd6);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf.clr", 8'(overflow0), 8'h00);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf.valid%0d", k), 8'(evt_valid0), 8'h01);
         chk($sformatf("ovf.code%0d", k), evt_code0, seq_codes[k]);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("ovf.empty", 8'(evt_valid0), 8'h00);

      // Reset after a lone E0 prefix.
      do_reset();
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'hE0, 1'b0, 1'b0);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("midrst.cnt0", press_count0, 8'd0);
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      chk("midrst.valid", 8'(evt_valid0), 8'h01);
      chk("midrst.code", evt_code0, 8'h1C);
      chk("midrst.ext", 8'(evt_ext0), 8'h00);
      chk("midrst.brk", 8'(evt_break0), 8'h00);
      chk("midrst.cnt", press_count0, 8'd1);

      // Press counter wrap over 256 make/break pairs.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         c = (i % 2 == 1) ? 8'h32 : 8'h1C;
         step(1'b1, c, 1'b1, 1'b0);
         step(1'b1, 8'hF0, 1'b1, 1'b0);
         step(1'b1, c, 1'b1, 1'b0);
         if (i == 254) chk("wrap.cnt255", press_count0, 8'hFF);
      end
      chk("wrap.cnt", press_count0, 8'h00);
      chk("wrap.held", 8'(key_held0), 8'h00);
      chk("wrap.ovf", 8'(overflow0), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
